bcd_serial: RTL and testbench

//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/bcd_serial.sv | 165 ++++++++++++++++
 tb/tb_bcd_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial.sv
//------------------------------------------------------------------------------
// bcd_serial
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   One input bit is consumed per clock, so a conversion takes IN_WIDTH clocks.
//   The published result (bcd/ovf) only changes on the done edge or on reset,
//   so downstream seven-segment decoders never see intermediate values.
//
// Ports
//   clk    in   1            system clock, rising edge
//   rst    in   1            asynchronous reset, active-high
//   start  in   1            conversion request, honoured only while idle
//   in     in   IN_WIDTH     binary value, captured on the accepting edge
//   busy   out  1            conversion in progress
//   done   out  1            one-cycle pulse: bcd/ovf were updated this cycle
//   bcd    out  4*DIGITS     result, digit i at bcd[4i+3:4i], digit 0 = ones
//   ovf    out  1            last input did not fit in DIGITS decimal digits
//------------------------------------------------------------------------------
module bcd_serial #(
   parameter int IN_WIDTH = 6,
   parameter int DIGITS   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_WIDTH-1:0]   in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(IN_WIDTH + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] bin_q, bin_d;
   logic [SW-1:0]       dig_q, dig_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_acc_q, ovf_acc_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SW-1:0]       bcd_q, bcd_d;
   logic                ovf_q, ovf_d;

   logic [SW-1:0]       dig_adj;
   logic [SW-1:0]       dig_shift;
   logic                carry_out;
   logic                last_step;

   // State and datapath registers; reset clears everything, aborting any conversion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bin_q     <= '0;
         dig_q     <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         dig_q     <= dig_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift {digits,bin} left
   always_comb begin
      dig_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q[4*i +: 4] >= 4'd5) begin
            dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
         end else begin
            dig_adj[4*i +: 4] = dig_q[4*i +: 4];
         end
      end
      dig_shift = {dig_adj[SW-2:0], bin_q[IN_WIDTH-1]};
      // A bit leaving the top digit means the value no longer fits in DIGITS digits
      carry_out = dig_adj[SW-1];
      last_step = (state_q == S_CONV) && (cnt_q == CW'(IN_WIDTH - 1));
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CONV;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CONV: begin
            if (last_step) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CONV;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output updates per state; bcd/ovf are only written on the last step
   always_comb begin
      bin_d     = bin_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d     = in;
               dig_d     = '0;
               cnt_d     = '0;
               ovf_acc_d = 1'b0;
               busy_d    = 1'b1;
            end else begin
               busy_d    = 1'b0;
            end
         end
         S_CONV: begin
            bin_d     = bin_q << 1;
            dig_d     = dig_shift;
            cnt_d     = cnt_q + CW'(1);
            ovf_acc_d = ovf_acc_q | carry_out;
            if (last_step) begin
               bcd_d  = dig_shift;
               ovf_d  = ovf_acc_q | carry_out;
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_serial.sv
//------------------------------------------------------------------------------
// tb_bcd_serial
//   Three converter instances: (6 bits, 2 digits), (6 bits, 1 digit) and
//   (16 bits, 5 digits). Each has a cycle-level acceptance model that pushes
//   the arithmetically computed decimal result into a queue when a start is
//   accepted; a monitor pops and compares on every done pulse, and checks that
//   busy/done timing matches and that bcd/ovf hold between results.
//------------------------------------------------------------------------------
module tb_bcd_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_s [3];
   logic [15:0] in_s    [3];
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [7:0]  bcd0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Decimal digits of v taken with plain division, plus the does-not-fit flag
   function automatic logic [20:0] ref_conv(input int unsigned v, input int digits);
      int unsigned r   = v;
      int unsigned lim = 1;
      logic [19:0] b   = '0;
      for (int i = 0; i < digits; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r           = r / 10;
         lim         = lim * 10;
      end
      return {(v >= lim), b};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int IW = (g == 2) ? 16 : 6;
      localparam int DG = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      logic [IW-1:0]   in_w;
      logic [4*DG-1:0] bcd_o;
      logic            busy_o, done_o, ovf_o;
      logic [20:0]     exp_q [$];
      int              left     = 0;
      bit              exp_done = 1'b0;
      logic [20:0]     last     = '0;

      assign in_w      = in_s[g][IW-1:0];
      assign busy_v[g] = busy_o;
      assign done_v[g] = done_o;
      if (g == 0) begin : g_tap
         assign bcd0 = bcd_o[7:0];
      end

      bcd_serial #(.IN_WIDTH(IW), .DIGITS(DG)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_s[g]),
         .in    (in_w),
         .busy  (busy_o),
         .done  (done_o),
         .bcd   (bcd_o),
         .ovf   (ovf_o)
      );

      // Acceptance model: idle converter takes a start, then is busy IW edges
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            exp_q.delete();
            left     = 0;
            exp_done = 1'b0;
         end else begin
            exp_done = 1'b0;
            if (left > 0) begin
               left--;
               if (left == 0) exp_done = 1'b1;
            end else if (start_s[g]) begin
               exp_q.push_back(ref_conv(32'(in_w), DG));
               left = IW;
            end
         end
      end

      // Monitor: timing of busy/done, result on done, held value otherwise
      always @(negedge clk) begin : mon
         logic [20:0] e;
         if (rst) last = '0;
         chk($sformatf("busy[%0d]", g), 32'(busy_o), 32'(left > 0));
         chk($sformatf("done[%0d]", g), 32'(done_o), 32'(exp_done));
         if (done_o) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("spurious_done[%0d]", g), 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("result[%0d]", g), 32'({ovf_o, 20'(bcd_o)}), 32'(e));
               last = e;
            end
         end else begin
            chk($sformatf("hold[%0d]", g), 32'({ovf_o, 20'(bcd_o)}), 32'(last));
         end
      end
   end

   // Single-cycle start pulse, then wait past the done pulse
   task automatic issue(input int g, input int unsigned v);
      @(posedge clk); #1;
      start_s[g] = 1'b1;
      in_s[g]    = 16'(v);
      @(posedge clk); #1;
      start_s[g] = 1'b0;
      in_s[g]    = 16'($urandom);
      repeat ((g == 2) ? 18 : 8) @(posedge clk);
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         start_s[g] = 1'b0;
         in_s[g]    = 16'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      issue(0, 63);
      issue(0, 0);
      issue(0, 10);
      issue(1, 45);
      issue(1, 9);
      issue(1, 10);
      issue(2, 65535);
      issue(2, 0);
      issue(2, 9999);
      issue(2, 10000);

      // Full sweep of the 6-bit range on both small instances
      for (int v = 0; v < 64; v++) begin
         issue(0, v);
         issue(1, v);
      end

      // Random values on the wide instance
      for (int n = 0; n < 30; n++) begin
         issue(2, $urandom_range(65535, 0));
      end

      // start held high with in changing every cycle: accepts only when idle
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         start_s[0] = 1'b1;
         start_s[1] = 1'b1;
         start_s[2] = 1'b1;
         in_s[0]    = 16'($urandom);
         in_s[1]    = 16'($urandom);
         in_s[2]    = 16'($urandom);
      end
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      start_s[2] = 1'b0;
      repeat (20) @(posedge clk);

      // Reset three clocks into a conversion of 42 aborts it immediately
      issue(0, 99);
      @(posedge clk); #1;
      start_s[0] = 1'b1;
      in_s[0]    = 16'd42;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy_v[0]), 32'(0));
      chk("rst_done", 32'(done_v[0]), 32'(0));
      chk("rst_bcd",  32'(bcd0),      32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(0, 42);

      repeat (4) @(posedge clk);
      chk("pending[0]", 32'(g_inst[0].exp_q.size()), 32'(0));
      chk("pending[1]", 32'(g_inst[1].exp_q.size()), 32'(0));
      chk("pending[2]", 32'(g_inst[2].exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
